// File: rtl/alu_button_core.sv
// Debounced switch/button front end with a registered ALU driving LEDS/STATUS.
// Define ALU_ACC_EN to enable BUTTONS[3] as an accumulate (A <= LEDS) button.
module alu_button_core #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SIZEOP          = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] SWITCHES,
  input  logic [3:0]        BUTTONS,
  output logic [DATA_W-1:0] LEDS,
  output logic [2:0]        STATUS
);

`ifdef ALU_ACC_EN
  localparam int unsigned NBTN = 4;
`else
  localparam int unsigned NBTN = 3;
  logic acc_unused;
  assign acc_unused = BUTTONS[3];
`endif

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [SIZEOP-1:0] OP_ADD = SIZEOP'(6'b100000);
  localparam logic [SIZEOP-1:0] OP_SUB = SIZEOP'(6'b100010);
  localparam logic [SIZEOP-1:0] OP_AND = SIZEOP'(6'b100100);
  localparam logic [SIZEOP-1:0] OP_OR  = SIZEOP'(6'b100101);
  localparam logic [SIZEOP-1:0] OP_XOR = SIZEOP'(6'b100110);
  localparam logic [SIZEOP-1:0] OP_NOR = SIZEOP'(6'b100111);
  localparam logic [SIZEOP-1:0] OP_SRL = SIZEOP'(6'b000010);
  localparam logic [SIZEOP-1:0] OP_SRA = SIZEOP'(6'b000011);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM_HIGH, ST_HELD, ST_ARM_LOW} db_state_e;

  logic [NBTN-1:0]   sync1;
  logic [NBTN-1:0]   sync2;
  logic [NBTN-1:0]   press;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [SIZEOP-1:0] reg_op;
  logic [DATA_W-1:0] result_c;
  logic              ovf_c;
  logic              err_c;
  logic              big_shift_c;

  // Two-flop synchronisers for the raw buttons
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= BUTTONS[NBTN-1:0];
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    db_state_e        state;
    db_state_e        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_c;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    // cnt holds the number of consecutive qualifying samples seen so far
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
        ST_IDLE: begin
          if (sync2[i]) begin
            state_next = ST_ARM_HIGH;
            cnt_next   = CNT_W'(1);
          end
        end
        ST_ARM_HIGH: begin
          if (cnt == CNT_MAX) begin
            state_next = ST_HELD;
            cnt_next   = '0;
          end else if (!sync2[i]) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!sync2[i]) begin
            state_next = ST_ARM_LOW;
            cnt_next   = CNT_W'(1);
          end
        end
        ST_ARM_LOW: begin
          if (cnt == CNT_MAX) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (sync2[i]) begin
            state_next = ST_HELD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    always_comb begin
      pulse_c = 1'b0;
      if (state == ST_ARM_HIGH && cnt == CNT_MAX) pulse_c = 1'b1;
    end

    assign press[i] = pulse_c;
  end

  // Operand/opcode registers; accumulate beats load-A when both pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= OP_ADD;
    end else begin
`ifdef ALU_ACC_EN
      if (press[3])      reg_a <= LEDS;
      else if (press[0]) reg_a <= SWITCHES;
`else
      if (press[0]) reg_a <= SWITCHES;
`endif
      if (press[1]) reg_b  <= SWITCHES;
      if (press[2]) reg_op <= SWITCHES[SIZEOP-1:0];
    end
  end

  assign big_shift_c = (reg_b >= DATA_W'(DATA_W));

  always_comb begin
    result_c = '0;
    ovf_c    = 1'b0;
    err_c    = 1'b0;
    case (reg_op)
      OP_ADD: begin
        result_c = reg_a + reg_b;
        ovf_c    = (reg_a[MSB] == reg_b[MSB]) && (result_c[MSB] != reg_a[MSB]);
      end
      OP_SUB: begin
        result_c = reg_a - reg_b;
        ovf_c    = (reg_a[MSB] != reg_b[MSB]) && (result_c[MSB] != reg_a[MSB]);
      end
      OP_AND: result_c = reg_a & reg_b;
      OP_OR:  result_c = reg_a | reg_b;
      OP_XOR: result_c = reg_a ^ reg_b;
      OP_NOR: result_c = ~(reg_a | reg_b);
      OP_SRL: result_c = big_shift_c ? '0 : (reg_a >> reg_b);
      OP_SRA: result_c = big_shift_c ? {DATA_W{reg_a[MSB]}}
                                     : DATA_W'($signed(reg_a) >>> reg_b);
      default: err_c = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS   <= '0;
      STATUS <= 3'b001;
    end else begin
      LEDS   <= result_c;
      STATUS <= {err_c, ovf_c, (result_c == '0)};
    end
  end

endmodule

// File: tb/tb_alu_button_core.sv
// Bench for alu_button_core: vector table, debounce/reset sequences and a
// randomized run against an arithmetic reference model.
module tb_alu_button_core;
  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic [3:0] btn;
  logic [7:0] leds;
  logic [2:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_a, m_b;
  logic [5:0] m_op;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] leds;
    logic [2:0] st;
  } vec_t;

  vec_t       vecs[13];
  logic [5:0] ops[8];

`ifdef ALU_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  alu_button_core #(.DATA_W(8), .SIZEOP(6), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(clk), .RESET(rst), .SWITCHES(sw), .BUTTONS(btn), .LEDS(leds), .STATUS(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Returns {op_err, ovf, zero, result} from signed/unsigned integer arithmetic
  function automatic logic [10:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    int sa, sb, r, p;
    logic e, o;
    logic [7:0] res;
    sa = int'(a); if (sa > 127) sa -= 256;
    sb = int'(b); if (sb > 127) sb -= 256;
    e = 1'b0; o = 1'b0; r = 0;
    case (op)
      6'h20: begin r = sa + sb; o = (r > 127) || (r < -128); end
      6'h22: begin r = sa - sb; o = (r > 127) || (r < -128); end
      6'h24: r = int'(a & b);
      6'h25: r = int'(a | b);
      6'h26: r = int'(a ^ b);
      6'h27: r = 255 - int'(a | b);
      6'h02: r = (b >= 8) ? 0 : int'(a) / (1 << b);
      6'h03: begin
        if (b >= 8) r = (sa < 0) ? -1 : 0;
        else begin
          p = 1 << b;
          r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        end
      end
      default: e = 1'b1;
    endcase
    res = 8'(r);
    return {e, o, (res == 8'h00), res};
  endfunction

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h20;
  endtask

  // Debounced press of every button in mask, then a fully debounced release
  task automatic press(input logic [3:0] mask, input logic [7:0] v);
    logic [10:0] cur;
    cur = ref_alu(m_a, m_b, m_op);
    sw  = v;
    btn = mask;
    tick(8);
    btn = 4'b0000;
    tick(12);
    if (ACC && mask[3]) m_a = cur[7:0];
    else if (mask[0])   m_a = v;
    if (mask[1]) m_b  = v;
    if (mask[2]) m_op = v[5:0];
  endtask

  task automatic load_all(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    press(4'b0001, a);
    press(4'b0010, b);
    press(4'b0100, {2'b00, op});
  endtask

  initial begin
    logic [10:0] exp;
    logic [3:0]  mask;
    logic [7:0]  v;

    vecs[0]  = '{8'h05, 8'h03, 6'h20, 8'h08, 3'b000};
    vecs[1]  = '{8'h05, 8'h03, 6'h22, 8'h02, 3'b000};
    vecs[2]  = '{8'h05, 8'h03, 6'h3F, 8'h00, 3'b101};
    vecs[3]  = '{8'h7F, 8'h01, 6'h20, 8'h80, 3'b010};
    vecs[4]  = '{8'h80, 8'h01, 6'h22, 8'h7F, 3'b010};
    vecs[5]  = '{8'h90, 8'h03, 6'h03, 8'hF2, 3'b000};
    vecs[6]  = '{8'h90, 8'h03, 6'h02, 8'h12, 3'b000};
    vecs[7]  = '{8'h90, 8'h09, 6'h03, 8'hFF, 3'b000};
    vecs[8]  = '{8'h90, 8'h09, 6'h02, 8'h00, 3'b001};
    vecs[9]  = '{8'hF0, 8'h0F, 6'h24, 8'h00, 3'b001};
    vecs[10] = '{8'hF0, 8'h0F, 6'h25, 8'hFF, 3'b000};
    vecs[11] = '{8'hF0, 8'h3C, 6'h26, 8'hCC, 3'b000};
    vecs[12] = '{8'hF0, 8'h3C, 6'h27, 8'h03, 3'b000};
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

    // Reset and idle hold
    rst = 1'b1; btn = 4'b0000; sw = 8'h00;
    model_reset();
    tick(2);
    check("reset leds", leds, 8'h00);
    check("reset status", {5'b0, status}, 8'h01);
    rst = 1'b0;
    tick(10);
    check("idle leds", leds, 8'h00);
    check("idle status", {5'b0, status}, 8'h01);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      load_all(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("vec%0d leds", i), leds, vecs[i].leds);
      check($sformatf("vec%0d status", i), {5'b0, status}, {5'b0, vecs[i].st});
    end

    // Debounce: exact latency, single load while held, glitch, short press
    load_all(8'h11, 8'h00, 6'h20);
    check("db setup", leds, 8'h11);
    sw = 8'hAA; btn = 4'b0001;
    tick(7);
    check("db latency early", leds, 8'h11);
    tick(1);
    check("db latency load", leds, 8'hAA);
    sw = 8'h55;
    tick(12);
    check("db held once", leds, 8'hAA);
    btn = 4'b0000; tick(2); btn = 4'b0001; tick(6);
    check("db glitch", leds, 8'hAA);
    btn = 4'b0000; tick(12);
    check("db release", leds, 8'hAA);
    sw = 8'h33; btn = 4'b0001; tick(3); btn = 4'b0000; tick(15);
    check("db short press", leds, 8'hAA);
    m_a = 8'hAA;

    // Randomized loads against the reference model
    for (int i = 0; i < 30; i++) begin
      mask = 4'($urandom_range(1, 7));
      v = 8'($urandom);
      if (mask[2] && $urandom_range(0, 3) != 0) v[5:0] = ops[$urandom_range(0, 7)];
      press(mask, v);
      exp = ref_alu(m_a, m_b, m_op);
      check($sformatf("rand%0d leds", i), leds, exp[7:0]);
      check($sformatf("rand%0d status", i), {5'b0, status}, {5'b0, exp[10:8]});
    end

    // Accumulator chain and accumulate-vs-load-A priority
    rst = 1'b1; tick(1); rst = 1'b0; model_reset();
    load_all(8'h01, 8'h01, 6'h20);
    check("acc setup", leds, 8'h02);
    press(4'b1000, 8'h00);
    check("acc 1", leds, ACC ? 8'h03 : 8'h02);
    press(4'b1000, 8'h00);
    check("acc 2", leds, ACC ? 8'h04 : 8'h02);
    press(4'b1000, 8'h00);
    check("acc 3", leds, ACC ? 8'h05 : 8'h02);
    press(4'b1001, 8'h40);
    check("acc priority", leds, ACC ? 8'h06 : 8'h41);

    // Reset during the second accumulate press's arming phase
    load_all(8'h01, 8'h01, 6'h20);
    press(4'b1000, 8'h00);
    check("rst setup", leds, ACC ? 8'h03 : 8'h02);
    btn = 4'b1000;
    tick(4);
    rst = 1'b1; tick(1);
    check("rst leds", leds, 8'h00);
    check("rst status", {5'b0, status}, 8'h01);
    rst = 1'b0; model_reset();
    tick(8);
    btn = 4'b0000;
    tick(12);
    check("rst fresh press", leds, 8'h00);
    press(4'b0010, 8'h01);
    check("rst a zero", leds, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
